// File: rtl/csa_accumulate_controller_pkg.sv
// Shared types and width helper for the carry-save accumulate controller.
// Holds the FSM state encoding and the accumulator width rule.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } csa_acc_state_t;

    // Headroom of clog2(max_ops) bits keeps max_ops full-scale operands exact.
    function automatic int acc_width(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

endpackage

// File: rtl/csa_accumulate_controller_if.sv
// Job, operand and result handshake bundle for the accumulate controller.
// master: producer/consumer side; slave: the controller.
// Signals: start, num_ops, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_sum, busy, err.
interface csa_accumulate_controller_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16
);
    import csa_acc_pkg::*;

    localparam int ACCW = acc_width(WIDTH, MAX_OPS);
    localparam int CNTW = $clog2(MAX_OPS + 1);

    logic            start;
    logic [CNTW-1:0] num_ops;
    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_sum;
    logic            busy;
    logic            err;

    modport master (
        output start, num_ops, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy, err
    );

    modport slave (
        input  start, num_ops, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy, err
    );

endinterface

// File: rtl/csa_accumulate_controller_csa.sv
// Bitwise 3:2 carry-save cell.
// Ports: i_a/i_b/i_c addends; o_sum parity vector; o_carry majority << 1.
module carry_save_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;

endmodule

// File: rtl/csa_accumulate_controller.sv
// Sequential multi-operand accumulator: one 3:2 CSA step per operand,
// one carry-propagate add at the end. Ports: clk, rst (sync, high), bus.
// Macro CSA_ACC_SIGNED_EN: operands are two's-complement (sign-extended).
module csa_accumulate_controller
    import csa_acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16
) (
    input logic                          clk,
    input logic                          rst,
    csa_accumulate_controller_if.slave   bus
);

    localparam int ACCW = acc_width(WIDTH, MAX_OPS);
    localparam int CNTW = $clog2(MAX_OPS + 1);

    csa_acc_state_t  r_state;
    csa_acc_state_t  w_state_nxt;

    logic [ACCW-1:0] r_s;
    logic [ACCW-1:0] r_c;
    logic [ACCW-1:0] r_sum;
    logic            r_err;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] r_nops;

    logic [ACCW-1:0] w_x;
    logic [ACCW-1:0] w_csa_s;
    logic [ACCW-1:0] w_csa_c;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            w_zero;
    logic            w_bad;
    logic            w_go;
    logic            w_accept;
    logic            w_resolve;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_busy;

`ifdef CSA_ACC_SIGNED_EN
    assign w_x = ACCW'(signed'(bus.in_data));
`else
    assign w_x = ACCW'(bus.in_data);
`endif

    assign w_zero    = (bus.num_ops == '0);
    assign w_bad     = (bus.num_ops > CNTW'(MAX_OPS));
    assign w_cnt_nxt = r_cnt + CNTW'(1);

    carry_save_adder #(
        .WIDTH (ACCW)
    ) u_csa (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_x),
        .o_sum   (w_csa_s),
        .o_carry (w_csa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_accept    = 1'b0;
        w_resolve   = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_go        = 1'b1;
                    w_state_nxt = (w_zero || w_bad) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (w_cnt_nxt == r_nops) begin
                        w_state_nxt = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                w_resolve   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new job clears the result too, so empty and rejected jobs report 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_c    <= '0;
            r_cnt  <= '0;
            r_nops <= '0;
            r_sum  <= '0;
            r_err  <= 1'b0;
        end else if (w_go) begin
            r_s    <= '0;
            r_c    <= '0;
            r_cnt  <= '0;
            r_nops <= bus.num_ops;
            r_sum  <= '0;
            r_err  <= w_bad;
        end else if (w_accept) begin
            r_s   <= w_csa_s;
            r_c   <= w_csa_c;
            r_cnt <= w_cnt_nxt;
        end else if (w_resolve) begin
            r_sum <= r_s + r_c;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_sum   = r_sum;
    assign bus.err       = r_err;

endmodule

// File: doc/csa_accumulate_controller.md
Name: csa_accumulate_controller

Overview:
- Sequential multi-operand accumulator. Streams WIDTH-bit operands one per cycle through a single ACCW-wide 3:2 carry-save cell, then resolves the result once.
- Running result is held in redundant form (sum vector + carry vector).
- After the last operand, a single carry-propagate add resolves the two vectors and the result is returned over a valid/ready handshake.
- Sits between an operand producer and a consumer; replaces a wide combinational multi-operand CSA tree where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits.
- MAX_OPS, 16, maximum operands per job (must be >= 1).
- ACCW, WIDTH+$clog2(MAX_OPS), accumulator/result width (derived localparam, not overridable).
- CNTW, $clog2(MAX_OPS+1), width of operand count (derived localparam).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  job request; sampled only in IDLE.
- num_ops  input  CNTW  operand count for the job; latched on accepted start.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller accepts an operand this cycle.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACCW  resolved sum, modulo 2^ACCW.
- busy  output  1  high in any state other than IDLE.
- err  output  1  job rejected because num_ops > MAX_OPS; valid while out_valid is high.

Behaviour:
- Reset: all outputs 0, state IDLE, S/C vectors and counter cleared. Reset wins over every other event, including mid-ACCUM and mid-DONE; any in-flight job is discarded.
- States and transitions:
  - IDLE -> ACCUM on start when 1 <= num_ops <= MAX_OPS.
  - IDLE -> DONE on start when num_ops == 0 (out_sum = 0, err = 0).
  - IDLE -> DONE on start when num_ops > MAX_OPS (out_sum = 0, err = 1).
  - ACCUM -> RESOLVE when an operand is accepted and the count reaches num_ops.
  - RESOLVE -> DONE after exactly 1 cycle.
  - DONE -> IDLE when out_valid && out_ready.
- On any IDLE -> ACCUM or IDLE -> DONE transition, clear S, C and the counter.
- in_ready = 1 only in ACCUM.
- Accept condition: in_valid && in_ready. On accept:
  - x = zero-extended in_data.
  - S <= S ^ C ^ x.
  - C <= (majority(S, C, x) << 1), truncated to ACCW bits.
  - count increments.
- No accept occurs in cycles where in_valid = 0; gaps of any length are allowed.
- RESOLVE: out_sum register <= S + C (ACCW bits, carry-out discarded).
- DONE: out_valid = 1. out_sum and err stay stable until the handshake completes.
- start while busy is ignored; it is not queued.
- Latency: out_valid rises 2 cycles after the last operand is accepted; 1 cycle after start for the zero-ops and error cases.
- Back-to-back jobs: start is accepted in the IDLE cycle following the handshake. Minimum job throughput = num_ops + 3 cycles.
- ACCW guarantees no overflow for MAX_OPS unsigned operands.

Optional Feature:
- Macro: CSA_ACC_SIGNED_EN.
- Defined: operands are two's-complement; x = sign-extended in_data. out_sum is the signed ACCW-bit sum.
- Undefined: operands are unsigned; x = zero-extended in_data.

Decomposition:
- Package csa_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} csa_acc_state_t;
  - a function acc_width(WIDTH, MAX_OPS) that returns ACCW.
- One sub-module: instantiate the existing carry_save_adder cell with WIDTH = ACCW for the 3:2 step. The controller holds all registers and the final adder.

Test Plan:
- num_ops=4, operands 10, 20, 30, 40 with in_valid continuous -> out_sum=100, err=0, out_valid 2 cycles after the 4th accept.
- num_ops=16, all operands 255 -> out_sum=4080 (0xFF0), no wrap; in_valid toggled every other cycle gives the same result.
- num_ops=0 -> out_valid next cycle, out_sum=0, err=0. num_ops=17 -> out_valid next cycle, out_sum=0, err=1.
- out_ready held low 5 cycles in DONE, with start pulsed during that window -> out_sum stable, start ignored, busy=1; IDLE after the handshake, then a new job runs correctly.
- rst asserted after 2 of 4 operands -> next cycle all outputs 0 and state IDLE; a fresh job with 1, 2, 3 -> out_sum=6.
- num_ops=3, operands 0xFF x3 -> out_sum=765 without CSA_ACC_SIGNED_EN; out_sum=0xFFD (-3) with it.
